dmem_line_ctrl: RTL and testbench
=================================

# dmem_line_ctrl

Line-granular data memory behind the L1 data cache. It accepts one 256-bit line read or write per request over the `mem_enable`/`mem_write`/`mem_ack` handshake the data cache drives. It completes each request after a fixed, parameterised latency, modelling off-chip DRAM for the CPU top level and the testbenches. Each request ends with a single-cycle ack; read data is held stable until the next read completes.

## Interface
- `LATENCY`, 10: cycles from request sampling edge to ack; legal range 1..255.
- `INDEX_BITS`, 9: line index width; capacity is 2^INDEX_BITS lines of 32 bytes (default 16 KiB).
- `clk_i`  in  1  single clock; all state updates on rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `mem_enable_i`  in  1  request valid.
- `mem_write_i`  in  1  1 = line write, 0 = line read; sampled with request.
- `mem_addr_i`  in  32  byte address; bits [4:0] ignored; line index = bits [INDEX_BITS+4:5]; upper bits ignored (aliasing).
- `mem_data_i`  in  256  write line; sampled with request.
- `mem_ack_o`  out  1  one-cycle completion pulse.
- `mem_data_o`  out  256  read line; valid in the ack cycle of a read, held until the next read completes.

## Operation
- FSM states: IDLE, BUSY, ACK.
- IDLE: on a rising edge with `mem_enable_i`=1, latch write flag, line index and write data; clear the latency counter. Go to BUSY, or to ACK directly if LATENCY=1.
- BUSY: increment the counter each cycle. When the counter reaches LATENCY-2, go to ACK. Inputs are ignored in BUSY; dropping `mem_enable_i` does not cancel the latched request.
- ACK: `mem_ack_o`=1 for exactly this cycle.
  - Write: the array line is updated at the edge ending ACK.
  - Read: `mem_data_o` is loaded from the array on the edge entering ACK.
  - Next state is always IDLE; inputs in the ACK cycle are not sampled.
- Back-to-back requests: the requester changes `enable`/`write`/`addr` on the ack edge. IDLE samples them on the following edge, giving a minimum one-cycle gap between ack and the next sampling edge.
- Read-after-write to the same line returns the newly written data.
- Width rules: no partial-line writes; the full 256 bits are always written.

## Timing
- Request sampled at edge E0; `mem_ack_o` high in the cycle following edge E0+LATENCY-1. The ack cycle is the LATENCY-th cycle after E0.
- Total throughput: one request per LATENCY+1 cycles when the requester re-asserts immediately.
- Reset values:
  - state IDLE, counter 0.
  - `mem_ack_o`=0, `mem_data_o`=0.
  - Array contents not cleared.
- Reset asserted mid-BUSY or in ACK: next cycle IDLE, no ack; a pending write is discarded.
- Reset concurrent with `mem_enable_i`: reset wins; the request is not sampled.

## Configuration
- `DMEM_PERF_CNT_EN` defined:
  - Adds outputs `rd_cnt_o` [31:0] and `wr_cnt_o` [31:0].
  - Each increments on the ack edge of its request type and wraps at 2^32.
  - Both reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `dmem_pkg`:
  - `LINE_BITS`=256, `OFFSET_BITS`=5, `ADDR_BITS`=32.
  - FSM state typedef (2-bit enum IDLE/BUSY/ACK).
  - Counter width constant (8).
- Sub-module `dmem_line_array`: 2^INDEX_BITS × 256 storage with synchronous write enable and combinational read from the latched index. The controller owns all sequencing.

## Test plan
- Read after reset, LATENCY=10, addr 0x0000_0040: ack exactly 10 cycles after the sampling edge, one cycle wide; `mem_data_o` equals the preloaded line 2.
- Write 0xA5…A5 to addr 0x0000_0120, then read the same address: second ack returns 0xA5…A5; two acks spaced ≥11 cycles apart.
- Writeback-then-fill sequence: write to 0x100 with enable held high; on ack, switch to read 0x200 without dropping enable. The read is sampled one cycle after the first ack, and its ack arrives 10 cycles later.
- Drop `mem_enable_i` in cycle 3 of BUSY: ack still occurs at cycle 10; a write still lands.
- Assert `rst_i` in cycle 5 of a write to 0x40: no ack; a subsequent read of 0x40 returns the pre-write data; `mem_ack_o`=0 and `mem_data_o`=0 after reset.
- LATENCY=1, with `DMEM_PERF_CNT_EN` defined: ack in the cycle immediately after sampling. After 3 reads and 2 writes, `rd_cnt_o`=3 and `wr_cnt_o`=2.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and FSM state type for the line-granular data memory.
package dmem_pkg;

  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;
  localparam int ADDR_BITS   = 32;
  localparam int CNT_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Counter value on which BUSY hands over to ACK; unused when LATENCY is 1.
  function automatic logic [CNT_BITS-1:0] last_count(input int latency);
    return (latency >= 2) ? CNT_BITS'(latency - 2) : '0;
  endfunction

endpackage

// File: rtl/dmem_line_array.sv
// Line storage: synchronous full-line write, combinational read at the given index.
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int INDEX_BITS = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] index,
  input  logic [LINE_BITS-1:0]  wdata,
  output logic [LINE_BITS-1:0]  rdata
);

  logic [LINE_BITS-1:0] mem [2**INDEX_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[index] <= wdata;
  end

  assign rdata = mem[index];

endmodule

// File: rtl/dmem_line_ctrl.sv
// Fixed-latency line memory controller; DMEM_PERF_CNT_EN adds read/write completion counters.
// state | meaning
// IDLE  | waiting for mem_enable_i; request latched on the sampling edge
// BUSY  | counting latency, inputs ignored
// ACK   | one-cycle mem_ack_o; write lands on the edge leaving this state
module dmem_line_ctrl
  import dmem_pkg::*;
#(
  parameter int LATENCY    = 10,
  parameter int INDEX_BITS = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mem_enable_i,
  input  logic                 mem_write_i,
  input  logic [ADDR_BITS-1:0] mem_addr_i,
  input  logic [LINE_BITS-1:0] mem_data_i,
  output logic                 mem_ack_o,
  output logic [LINE_BITS-1:0] mem_data_o
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]          rd_cnt_o,
  output logic [31:0]          wr_cnt_o
`endif
);

  localparam logic [CNT_BITS-1:0] LAST_CNT = last_count(LATENCY);

  state_t                state, state_nxt;
  logic [CNT_BITS-1:0]   cnt;
  logic                  wr_q;
  logic [INDEX_BITS-1:0] index_q;
  logic [LINE_BITS-1:0]  wdata_q;
  logic [INDEX_BITS-1:0] index_in;
  logic [INDEX_BITS-1:0] array_index;
  logic [LINE_BITS-1:0]  array_rdata;
  logic                  array_we;
  logic                  load_rd;
  logic                  unused_addr;

  assign index_in    = mem_addr_i[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
  assign unused_addr = ^{mem_addr_i[ADDR_BITS-1:INDEX_BITS+OFFSET_BITS],
                         mem_addr_i[OFFSET_BITS-1:0]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_enable_i) state_nxt = (LATENCY == 1) ? ACK : BUSY;
      BUSY:    if (cnt == LAST_CNT) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY=1 the read goes straight from IDLE to ACK, so the array
  // must be addressed by the incoming request rather than the latched one.
  assign array_index = (LATENCY == 1 && state == IDLE) ? index_in : index_q;
  assign load_rd     = (state_nxt == ACK) && (state != ACK) &&
                       ((state == IDLE) ? !mem_write_i : !wr_q);
  assign array_we    = (state == ACK) && wr_q && !rst_i;
  assign mem_ack_o   = (state == ACK);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_data_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) cnt <= '0;
      else if (state == BUSY) cnt <= cnt + 1'b1;
      if (load_rd) mem_data_o <= array_rdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && state == IDLE && mem_enable_i) begin
      wr_q    <= mem_write_i;
      index_q <= index_in;
      wdata_q <= mem_data_i;
    end
  end

  dmem_line_array #(
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .clk  (clk_i),
    .we   (array_we),
    .index(array_index),
    .wdata(wdata_q),
    .rdata(array_rdata)
  );

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else if (state == ACK) begin
      if (wr_q) wr_cnt_o <= wr_cnt_o + 32'd1;
      else      rd_cnt_o <= rd_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Bench for dmem_line_ctrl: timestamp/dictionary model for LATENCY=10 plus directed LATENCY=1 checks.
module tb_dmem_line_ctrl;

  localparam int LAT = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, wr, ack;
  logic [31:0]  addr;
  logic [255:0] wdata, rdata;
  logic         rst1, en1, wr1, ack1;
  logic [31:0]  addr1;
  logic [255:0] wdata1, rdata1;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0]  rd_cnt0, wr_cnt0, rd_cnt1, wr_cnt1;
`endif

  dmem_line_ctrl #(.LATENCY(LAT), .INDEX_BITS(9)) u_dut (
    .clk_i(clk), .rst_i(rst), .mem_enable_i(en), .mem_write_i(wr),
    .mem_addr_i(addr), .mem_data_i(wdata), .mem_ack_o(ack), .mem_data_o(rdata)
`ifdef DMEM_PERF_CNT_EN
    , .rd_cnt_o(rd_cnt0), .wr_cnt_o(wr_cnt0)
`endif
  );

  dmem_line_ctrl #(.LATENCY(1), .INDEX_BITS(9)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .mem_enable_i(en1), .mem_write_i(wr1),
    .mem_addr_i(addr1), .mem_data_i(wdata1), .mem_ack_o(ack1), .mem_data_o(rdata1)
`ifdef DMEM_PERF_CNT_EN
    , .rd_cnt_o(rd_cnt1), .wr_cnt_o(wr_cnt1)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Model: a request taken at edge e0 acks in cycle e0+LAT-1 and retires on edge e0+LAT.
  logic [255:0] mdl_mem [int];
  int           edge_n = 0;
  bit           pend = 0;
  int           e0 = 0;
  bit           m_wr = 0;
  int           m_idx = 0;
  logic [255:0] m_data = '0;
  bit           exp_ack = 0;
  logic [255:0] exp_rd = '0;
  bit           exp_rd_known = 0;
  bit           model_live = 0;

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (rst) begin
      pend = 0;
      exp_rd = '0;
      exp_rd_known = 1;
      model_live = 1;
    end else if (pend) begin
      if (edge_n == e0 + LAT) begin
        if (m_wr) mdl_mem[m_idx] = m_data;
        pend = 0;
      end
    end else if (en) begin
      pend   = 1;
      e0     = edge_n;
      m_wr   = wr;
      m_idx  = int'(addr[13:5]);
      m_data = wdata;
    end
    if (pend && !m_wr && edge_n == e0 + LAT - 1) begin
      if (mdl_mem.exists(m_idx)) begin
        exp_rd = mdl_mem[m_idx];
        exp_rd_known = 1;
      end else begin
        exp_rd_known = 0;
      end
    end
    exp_ack = pend && (edge_n == e0 + LAT - 1);
  end

  always @(negedge clk) begin
    if (model_live) begin
      checks++;
      if (ack !== exp_ack) begin
        failures++;
        $display("FAIL model_ack cyc=%0d got %b want %b", edge_n, ack, exp_ack);
      end
      if (exp_rd_known) begin
        checks++;
        if (rdata !== exp_rd) begin
          failures++;
          $display("FAIL model_rdata cyc=%0d got %h want %h", edge_n, rdata, exp_rd);
        end
      end
    end
  end

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Drives a request at a negedge; returns sampling edge and ack cycle numbers.
  task automatic req(input bit w, input logic [31:0] a, input logic [255:0] d,
                     input int skip, output int samp, output int ackn);
    en = 1'b1; wr = w; addr = a; wdata = d;
    repeat (skip) @(posedge clk);
    @(posedge clk); #1;
    samp = edge_n;
    ackn = -1;
    for (int i = 0; i < 40 && ackn < 0; i++) begin
      @(negedge clk);
      if (ack === 1'b1) ackn = edge_n;
    end
    if (ackn < 0) begin
      checks++; failures++;
      $display("FAIL ack_timeout addr=%h got none want ack", a);
    end
  endtask

  task automatic req1(input bit w, input logic [31:0] a, input logic [255:0] d,
                      output logic [255:0] q);
    en1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d;
    @(posedge clk);
    @(negedge clk);
    check("lat1_ack_high", 256'(ack1), 256'(1));
    q = rdata1;
    en1 = 1'b0;
    @(negedge clk);
    check("lat1_ack_low", 256'(ack1), 256'(0));
  endtask

  localparam logic [255:0] P2 = {8{32'h0202_0202}};
  localparam logic [255:0] A5 = {32{8'hA5}};
  localparam logic [255:0] DX = {8{32'hDEAD_0100}};
  localparam logic [255:0] DY = {8{32'h1234_0200}};
  localparam logic [255:0] DZ = {8{32'h6060_6060}};
  localparam logic [255:0] DW = {8{32'hFFFF_0040}};

  initial begin
    int s, a, s2, a2;
    bit seen;
    logic [255:0] q;
    rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    rst1 = 1'b1; en1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    check("reset_ack", 256'(ack), 256'(0));
    check("reset_rdata", rdata, '0);
    rst = 1'b0;

    req(1'b1, 32'h0000_0040, P2, 0, s, a);
    en = 1'b0; @(negedge clk);
    req(1'b0, 32'h0000_0040, '0, 0, s, a);
    check("read_latency", 256'(a - s), 256'(9));  // ack cycle is the 10th counting the sampling cycle
    check("read_line2", rdata, P2);
    en = 1'b0; @(negedge clk);
    check("ack_one_wide", 256'(ack), 256'(0));

    req(1'b1, 32'h0000_0120, A5, 0, s, a);
    en = 1'b0; @(negedge clk);
    req(1'b0, 32'h0000_0120, '0, 0, s2, a2);
    check("raw_data", rdata, A5);
    check("ack_spacing_ge11", 256'(a2 - a >= 11), 256'(1));
    en = 1'b0; @(negedge clk);

    req(1'b1, 32'h0000_0200, DY, 0, s, a);
    en = 1'b0; @(negedge clk);
    req(1'b1, 32'h0000_0100, DX, 0, s, a);
    req(1'b0, 32'h0000_0200, '0, 1, s2, a2);
    check("fill_sample_gap", 256'(s2 - a), 256'(2));
    check("fill_latency", 256'(a2 - s2), 256'(9));
    check("fill_data", rdata, DY);
    en = 1'b0; @(negedge clk);

    en = 1'b1; wr = 1'b1; addr = 32'h0000_0060; wdata = DZ;
    @(posedge clk); #1; s = edge_n;
    repeat (3) @(negedge clk);
    en = 1'b0;
    a = -1;
    for (int i = 0; i < 40 && a < 0; i++) begin
      @(negedge clk);
      if (ack === 1'b1) a = edge_n;
    end
    check("drop_en_latency", 256'(a - s), 256'(9));
    @(negedge clk);
    req(1'b0, 32'h0000_0060, '0, 0, s, a);
    check("drop_en_write_landed", rdata, DZ);
    en = 1'b0; @(negedge clk);

    en = 1'b1; wr = 1'b1; addr = 32'h0000_0040; wdata = DW;
    @(posedge clk);
    repeat (5) @(negedge clk);
    en = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("midreset_ack", 256'(ack), 256'(0));
    check("midreset_rdata", rdata, '0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ack === 1'b1) seen = 1;
    end
    check("midreset_no_ack", 256'(seen), 256'(0));
    req(1'b0, 32'h0000_0040, '0, 0, s, a);
    check("midreset_write_discarded", rdata, P2);
    en = 1'b0; @(negedge clk);
`ifdef DMEM_PERF_CNT_EN
    check("cnt0_rd", 256'(rd_cnt0), 256'(1));
    check("cnt0_wr", 256'(wr_cnt0), 256'(0));
`endif

    rst1 = 1'b0;
    @(negedge clk);
    req1(1'b1, 32'h0000_0000, DX, q);
    req1(1'b1, 32'h0000_0020, DY, q);
    req1(1'b0, 32'h0000_0000, '0, q);
    check("lat1_read0", q, DX);
    req1(1'b0, 32'h0000_0020, '0, q);
    check("lat1_read1", q, DY);
    check("lat1_hold", rdata1, DY);
    req1(1'b0, 32'h0000_0000, '0, q);
    check("lat1_read0_again", q, DX);
`ifdef DMEM_PERF_CNT_EN
    check("lat1_rd_cnt", 256'(rd_cnt1), 256'(3));
    check("lat1_wr_cnt", 256'(wr_cnt1), 256'(2));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
